// File: rtl/generic_flash_access_nios2_cpu_mul_combine.sv
// Sequencer that drives an external three-cell 16x16 multiplier and combines
// its partial products into the low 32 bits of a 32x32 unsigned product.
// Operands go out registered on E_src1/E_src2. M_en is held high for
// MUL_LATENCY cycles. The result is then formed in one SUM cycle and
// presented with a valid/ready handshake.
module generic_flash_access_nios2_cpu_mul_combine #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        kill,
  output logic [31:0] E_src1,
  output logic [31:0] E_src2,
  output logic        M_en,
  input  logic [31:0] M_mul_cell_p1,
  input  logic [31:0] M_mul_cell_p2,
  input  logic [31:0] M_mul_cell_p3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SUM  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, next_state;
  logic [1:0]  mul_cnt;
  logic        accept;
  logic        mul_last;
  logic [31:0] cross_sum;

  // The last MUL cycle is reached once the counter has seen MUL_LATENCY-1 cycles.
  assign mul_last  = (mul_cnt == 2'(MUL_LATENCY - 1));

  // The cross terms only land in bits [31:16]. The shift drops their upper half.
  assign cross_sum = M_mul_cell_p2 + M_mul_cell_p3;

  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Next-state, handshake and multiplier enable decode; kill overrides everything.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    next_state = state;
    req_ready  = 1'b0;
    M_en       = 1'b0;
    case (state)
      IDLE: req_ready = 1'b1;
      MUL: begin
        M_en = ~kill;
        if (mul_last) next_state = SUM;
      end
      SUM:  next_state = DONE;
      DONE: begin
        req_ready = out_ready;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    accept = req_valid & req_ready & ~kill;
    if (accept) next_state = MUL;
    if (kill)   next_state = IDLE;
  end

  // State register and MUL-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state   <= IDLE;
      mul_cnt <= 2'd0;
    end else begin
      state   <= next_state;
      mul_cnt <= (state == MUL && next_state == MUL) ? mul_cnt + 2'd1 : 2'd0;
    end
  end

  // Operand capture on accept; the values stay frozen until the next accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      E_src1 <= 32'h0;
      E_src2 <= 32'h0;
    end else if (accept) begin
      E_src1 <= req_src1;
      E_src2 <= req_src2;
    end
  end

  // Result combine in SUM. Partial products are looked at only here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= 32'h0;
    end else if (state == SUM && !kill) begin
      result <= M_mul_cell_p1 + (cross_sum << 16);
    end
  end

endmodule

// File: tb/tb_generic_flash_access_nios2_cpu_mul_combine.sv
// Bench for the multiply-combine sequencer. It runs two instances on shared
// stimulus: u_l1 uses MUL_LATENCY=1 and u_l3 uses MUL_LATENCY=3. Each instance
// has its own 16x16 cell model. A transaction model tracks cycles since accept
// and computes the full product arithmetically.
module tb_generic_flash_access_nios2_cpu_mul_combine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_src1 = 32'h0;
  logic [31:0] req_src2 = 32'h0;
  logic        kill = 1'b0;
  logic        out_ready = 1'b1;

  logic        req_ready [2];
  logic [31:0] e_src1 [2];
  logic [31:0] e_src2 [2];
  logic        m_en [2];
  logic [31:0] p1 [2];
  logic [31:0] p2 [2];
  logic [31:0] p3 [2];
  logic        out_valid [2];
  logic [31:0] result [2];
  logic        busy [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  generic_flash_access_nios2_cpu_mul_combine #(.MUL_LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_src1(req_src1), .req_src2(req_src2), .kill(kill),
    .E_src1(e_src1[0]), .E_src2(e_src2[0]), .M_en(m_en[0]),
    .M_mul_cell_p1(p1[0]), .M_mul_cell_p2(p2[0]), .M_mul_cell_p3(p3[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready), .result(result[0]), .busy(busy[0])
  );

  generic_flash_access_nios2_cpu_mul_combine #(.MUL_LATENCY(3)) u_l3 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_src1(req_src1), .req_src2(req_src2), .kill(kill),
    .E_src1(e_src1[1]), .E_src2(e_src2[1]), .M_en(m_en[1]),
    .M_mul_cell_p1(p1[1]), .M_mul_cell_p2(p2[1]), .M_mul_cell_p3(p3[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready), .result(result[1]), .busy(busy[1])
  );

  // Multiplier cells: three registered 16x16 unsigned products, gated by M_en.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (m_en[k]) begin
        p1[k] <= 32'(e_src1[k][15:0]) * 32'(e_src2[k][15:0]);
        p2[k] <= 32'(e_src1[k][15:0]) * 32'(e_src2[k][31:16]);
        p3[k] <= 32'(e_src1[k][31:16]) * 32'(e_src2[k][15:0]);
      end
    end
  end

  // Transaction model. age counts cycles since accept: 1..lat is the multiply
  // window, lat+1 is the combine cycle, and lat+2 onward holds the result.
  int          lat [2] = '{1, 3};
  bit          act [2] = '{1'b0, 1'b0};
  int          age [2] = '{0, 0};
  logic [31:0] me1 [2] = '{32'h0, 32'h0};
  logic [31:0] me2 [2] = '{32'h0, 32'h0};
  logic [31:0] mres [2] = '{32'h0, 32'h0};

  function automatic bit mdl_valid(input int k);
    return act[k] && age[k] >= lat[k] + 2;
  endfunction

  function automatic bit mdl_ready(input int k);
    return !act[k] || (mdl_valid(k) && out_ready);
  endfunction

  function automatic bit mdl_men(input int k);
    return act[k] && age[k] >= 1 && age[k] <= lat[k] && !kill;
  endfunction

  // Model update at each clock edge, or immediately when reset rises.
  always @(posedge clk or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        act[k]  <= 1'b0;
        age[k]  <= 0;
        me1[k]  <= 32'h0;
        me2[k]  <= 32'h0;
        mres[k] <= 32'h0;
      end else if (kill) begin
        act[k] <= 1'b0;
        age[k] <= 0;
      end else begin
        if (act[k] && age[k] == lat[k] + 1) mres[k] <= me1[k] * me2[k];
        if (req_valid && mdl_ready(k)) begin
          act[k] <= 1'b1;
          age[k] <= 1;
          me1[k] <= req_src1;
          me2[k] <= req_src2;
        end else if (mdl_valid(k) && out_ready) begin
          act[k] <= 1'b0;
          age[k] <= 0;
        end else if (act[k] && age[k] < lat[k] + 2) begin
          age[k] <= age[k] + 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compare every output of both instances against the model on each falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      check($sformatf("u%0d req_ready", k), 32'(req_ready[k]), 32'(mdl_ready(k)));
      check($sformatf("u%0d m_en", k),      32'(m_en[k]),      32'(mdl_men(k)));
      check($sformatf("u%0d out_valid", k), 32'(out_valid[k]), 32'(mdl_valid(k)));
      check($sformatf("u%0d busy", k),      32'(busy[k]),      32'(act[k]));
      check($sformatf("u%0d e_src1", k),    e_src1[k],         me1[k]);
      check($sformatf("u%0d e_src2", k),    e_src2[k],         me2[k]);
      check($sformatf("u%0d result", k),    result[k],         mres[k]);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_src1  = a;
    req_src2  = b;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_valid(input int k, input int budget);
    int n = 0;
    while (!out_valid[k] && n < budget) begin
      step();
      n++;
    end
    check($sformatf("u%0d wait_valid", k), 32'(out_valid[k]), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy[0] || busy[1]) && n < budget) begin
      step();
      n++;
    end
    check("wait_idle", 32'(busy[0] | busy[1]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    step(2);
    check("rst result",    result[0],          32'h0);
    check("rst req_ready", 32'(req_ready[0]),  32'd1);
    check("rst busy",      32'(busy[1]),       32'd0);
    reset = 1'b0;
    step();

    // Basic product with MUL_LATENCY=1: M_en only at T+1, out_valid at T+3.
    send(32'h0001_0002, 32'h0003_0004);
    check("s1 m_en T+1", 32'(m_en[0]), 32'd1);
    step();
    check("s1 m_en T+2", 32'(m_en[0]), 32'd0);
    check("s1 valid T+2", 32'(out_valid[0]), 32'd0);
    step();
    check("s1 valid T+3", 32'(out_valid[0]), 32'd1);
    check("s1 result", result[0], 32'h000A_0008);
    step();
    check("s1 valid T+4", 32'(out_valid[0]), 32'd0);
    wait_idle(20);

    // All-ones operands: the carries above bit 31 must be discarded.
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_valid(0, 10);
    check("s2 result", result[0], 32'h0000_0001);
    wait_idle(20);

    // Backpressure: DONE holds for 5 cycles with a stable result.
    out_ready = 1'b0;
    send(32'h0000_0003, 32'h0000_0005);
    wait_valid(0, 10);
    for (int i = 0; i < 5; i++) begin
      check("s3 valid",  32'(out_valid[0]), 32'd1);
      check("s3 result", result[0], 32'h0000_000F);
      check("s3 ready",  32'(req_ready[0]), 32'd0);
      check("s3 m_en",   32'(m_en[0]), 32'd0);
      step();
    end
    out_ready = 1'b1;
    wait_idle(20);

    // Back-to-back: the second pair is accepted in the first result's DONE cycle.
    send(32'h0001_0002, 32'h0003_0004);
    wait_valid(0, 10);
    check("s4 first result", result[0], 32'h000A_0008);
    check("s4 handoff ready", 32'(req_ready[0]), 32'd1);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("s4 no bubble m_en", 32'(m_en[0]), 32'd1);
    check("s4 valid drop", 32'(out_valid[0]), 32'd0);
    wait_valid(0, 10);
    check("s4 second result", result[0], 32'h0000_0001);
    wait_idle(20);

    // Kill during MUL with MUL_LATENCY=3.
    send(32'h1234_5678, 32'h0000_0010);
    kill = 1'b1;
    #1;
    check("s5 m_en in kill", 32'(m_en[1]), 32'd0);
    step();
    kill = 1'b0;
    check("s5 idle after kill", 32'(busy[1]), 32'd0);
    check("s5 m_en after kill", 32'(m_en[1]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      check("s5 no valid", 32'(out_valid[1] | out_valid[0]), 32'd0);
      step();
    end

    // Reset pulsed during SUM of the latency-1 instance.
    send(32'h0000_0007, 32'h0000_0009);
    step();
    #2 reset = 1'b1;
    #1;
    check("s6 rst result",    result[0],         32'h0);
    check("s6 rst e_src1",    e_src1[0],         32'h0);
    check("s6 rst busy",      32'(busy[0]),      32'd0);
    check("s6 rst req_ready", 32'(req_ready[0]), 32'd1);
    check("s6 rst m_en l3",   32'(m_en[1]),      32'd0);
    step(2);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("s6 no stale valid", 32'(out_valid[0] | out_valid[1]), 32'd0);
      check("s6 no stale result", result[0], 32'h0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/generic_flash_access_nios2_cpu_mul_combine.md
GENERIC_FLASH_ACCESS_NIOS2_CPU_MUL_COMBINE -- requirements
Module: generic_flash_access_nios2_cpu_mul_combine

Interface
REQ-001 Parameter MUL_LATENCY, default 1, SHALL give the cycles M_en is held per operation; legal range 1..3.
REQ-002 clk  input  1  sole clock; all state SHALL update on rising edge.
REQ-003 reset  input  1  SHALL be asynchronous, active-high; asserted SHALL force reset state immediately.
REQ-004 req_valid  input  1  SHALL signal that the operand pair is valid.
REQ-005 req_ready  output  1  SHALL signal that the block accepts an operand pair.
REQ-006 req_src1, req_src2  input  32 each  SHALL carry the unsigned operands.
REQ-007 kill  input  1  SHALL abort any operation in flight (synchronous).
REQ-008 E_src1, E_src2  output  32 each  SHALL carry the registered operands to the multiplier cell.
REQ-009 M_en  output  1  SHALL be the multiplier-cell register enable.
REQ-010 M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3  input  32 each  SHALL carry the partial products lo*lo, lo(src1)*hi(src2), hi(src1)*lo(src2).
REQ-011 out_valid  output  1  SHALL signal that result is valid.
REQ-012 out_ready  input  1  SHALL signal that the consumer takes the result.
REQ-013 result  output  32  SHALL carry the low 32 bits of src1*src2.
REQ-014 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, MUL, SUM and DONE.
REQ-016 Accept SHALL occur in a cycle T when req_valid and req_ready are both high; req_src1/2 SHALL be captured into E_src1/2 at that edge; next state MUL.
REQ-017 req_ready SHALL be high in IDLE, and in DONE only while out_ready is high; low in MUL and SUM.
REQ-018 MUL: M_en SHALL be high for exactly MUL_LATENCY consecutive cycles T+1..T+MUL_LATENCY, counted by an internal counter; E_src1/2 SHALL stay stable throughout; then next state SUM.
REQ-019 M_en SHALL be low in every cycle outside MUL.
REQ-020 SUM (cycle T+MUL_LATENCY+1): result SHALL be registered as (p1 + ((p2 + p3) << 16)) mod 2^32; only bits [15:0] of p2+p3 SHALL contribute; carries beyond bit 31 SHALL be discarded; next state DONE.
REQ-021 DONE: out_valid SHALL be high from cycle T+MUL_LATENCY+2; result SHALL be held stable while out_valid is high and out_ready is low.
REQ-022 A DONE cycle with out_ready high and no accept SHALL go to IDLE, with out_valid low next cycle.
REQ-023 A DONE cycle with out_ready high and req_valid high SHALL hand off the result and accept the new pair in the same cycle; next state MUL; no bubble in IDLE.
REQ-024 kill high SHALL send the FSM to IDLE at the next edge from any state, with M_en low in that cycle, out_valid low next cycle, counter cleared and no result produced.
REQ-025 kill SHALL take priority over accept and handoff in the same cycle.
REQ-026 Partial-product inputs SHALL be sampled only in SUM.

Reset
REQ-027 While reset is high: state IDLE, counter 0, E_src1/E_src2/result 0x00000000, M_en/out_valid/busy 0, req_ready 1.
REQ-028 Reset asserted mid-operation SHALL discard the operation; after release no out_valid SHALL appear until a new accept.

Verification
REQ-029 The bench SHALL model the multiplier cell as three 16x16 unsigned registered products gated by M_en, and SHALL cover the scenarios below.
REQ-030 src1=0x00010002, src2=0x00030004, MUL_LATENCY=1, out_ready=1 -> M_en high at T+1 only; out_valid at T+3; result=0x000A0008.
REQ-031 src1=src2=0xFFFFFFFF -> result=0x00000001, checking carry discard.
REQ-032 out_ready held low 5 cycles in DONE -> out_valid high, result constant, req_ready low and M_en low for all 5 cycles.
REQ-033 Two ops queued, out_ready=1, second req_valid high in the first op's DONE cycle -> second accepted that cycle; results 0x000A0008 then 0x00000001, in order.
REQ-034 kill in MUL with MUL_LATENCY=3 -> IDLE next cycle, M_en low, no out_valid ever.
REQ-035 reset pulsed in SUM -> all outputs per REQ-027 immediately; no stale result after release.
